// File: rtl/config_pkg.sv
// ----------------------------------------------------------------------------
// config_pkg
// Shared constants and types for the ALU packet engine.
//   - Opcodes carried in the first header byte.
//   - ERR_BYTE: single byte returned for malformed packets when the build
//     defines ALU_PACKET_ERR_RESP_EN.
//   - HDR_BYTES: header size; the packet length field includes it.
//   - SER_CNT_W: width of the serializer byte-count load value.
//   - alu_pkt_state_e: engine FSM states (ERR exists only when
//     ALU_PACKET_ERR_RESP_EN is defined).
// ----------------------------------------------------------------------------
package config_pkg;

    localparam logic [7:0] OPCODE_ECHO = 8'hEC;
    localparam logic [7:0] OPCODE_ADD  = 8'hA0;
    localparam logic [7:0] OPCODE_MUL  = 8'hA1;
    localparam logic [7:0] OPCODE_DIV  = 8'hA2;

    localparam logic [7:0] ERR_BYTE  = 8'hEE;
    localparam int         HDR_BYTES = 4;

    // Enough for BYTES up to 8 (DATA_W = 64).
    localparam int SER_CNT_W = 4;

    typedef enum logic [3:0] {
        HDR_OP,
        HDR_RSV,
        LEN_LO,
        LEN_HI,
        ECHO,
        COLLECT,
        EXEC,
        RESULT,
        DRAIN
`ifdef ALU_PACKET_ERR_RESP_EN
        ,
        ERR
`endif
    } alu_pkt_state_e;

endpackage

// File: rtl/alu_result_serializer.sv
// ----------------------------------------------------------------------------
// alu_result_serializer
// Loads a DATA_W word together with a byte count and emits that many bytes,
// least significant first, over a valid/ready byte port.
//
// Handshake: a byte moves when tx_valid_o && tx_ready_i are both high at a
// rising clock edge; tx_valid_o and tx_data_o stay stable until then.
//
// Ports:
//   clk_i, rst_i     clock, asynchronous active-high reset
//   load_i           load request; honoured only while idle (!tx_valid_o)
//   load_word_i      word to send
//   load_cnt_i       number of bytes to send (0 loads nothing)
//   tx_data_o        current byte
//   tx_valid_o       byte valid
//   tx_ready_i       consumer accepts byte
//   done_o           one-cycle strobe on the handshake of the last byte
// ----------------------------------------------------------------------------
module alu_result_serializer
    import config_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 load_i,
    input  logic [DATA_W-1:0]    load_word_i,
    input  logic [SER_CNT_W-1:0] load_cnt_i,
    output logic [7:0]           tx_data_o,
    output logic                 tx_valid_o,
    input  logic                 tx_ready_i,
    output logic                 done_o
);

    logic [DATA_W-1:0]    shift_q, shift_d;
    logic [SER_CNT_W-1:0] cnt_q, cnt_d;
    logic                 valid_q, valid_d;
    logic                 tx_fire;

    assign tx_data_o  = shift_q[7:0];
    assign tx_valid_o = valid_q;
    assign tx_fire    = valid_q && tx_ready_i;
    assign done_o     = tx_fire && (cnt_q == SER_CNT_W'(1));

    always_comb begin
        shift_d = shift_q;
        cnt_d   = cnt_q;
        valid_d = valid_q;
        if (load_i && !valid_q) begin
            shift_d = load_word_i;
            cnt_d   = load_cnt_i;
            valid_d = (load_cnt_i != '0);
        end else if (tx_fire) begin
            shift_d = shift_q >> 8;
            cnt_d   = cnt_q - SER_CNT_W'(1);
            if (cnt_q == SER_CNT_W'(1)) begin
                valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            shift_q <= '0;
            cnt_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
        end
    end

endmodule

// File: rtl/alu_packet_engine.sv
// ----------------------------------------------------------------------------
// alu_packet_engine
// Byte-stream packet engine. Parses a 4-byte header (opcode, reserved,
// length LSB, length MSB; length includes the header), then either echoes
// the payload, folds little-endian DATA_W operands (ADD locally, MUL/DIV via
// an external unit) and returns the result LSB first, or drains a malformed
// packet.
//
// Build option: define ALU_PACKET_ERR_RESP_EN to answer malformed packets
// (unknown opcode, bad length, len < 4) with a single ERR_BYTE after the
// payload has been drained. Without it such packets are dropped silently.
//
// Handshakes (rx, tx, op request): a transfer happens at a rising edge where
// valid and ready are both high; the valid side holds its data stable until
// then. op_resp_valid_i is a one-cycle strobe with no ready.
//
// Ports:
//   clk_i, rst_i              clock, asynchronous active-high reset
//   rx_data_i/valid_i/ready_o received byte stream
//   tx_data_o/valid_o/ready_i transmitted byte stream
//   op_req_valid_o/ready_i    request to the MUL/DIV unit
//   op_sel_o                  0 = signed MUL, 1 = signed DIV (a/b)
//   op_a_o, op_b_o            accumulator and newest operand
//   op_resp_valid_i           result strobe
//   op_result_i               low DATA_W bits of the result
//   dbg_state_o               current FSM state (alu_pkt_state_e encoding)
// ----------------------------------------------------------------------------
module alu_packet_engine
    import config_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [7:0]        rx_data_i,
    input  logic              rx_valid_i,
    output logic              rx_ready_o,
    output logic [7:0]        tx_data_o,
    output logic              tx_valid_o,
    input  logic              tx_ready_i,
    output logic              op_req_valid_o,
    input  logic              op_req_ready_i,
    output logic              op_sel_o,
    output logic [DATA_W-1:0] op_a_o,
    output logic [DATA_W-1:0] op_b_o,
    input  logic              op_resp_valid_i,
    input  logic [DATA_W-1:0] op_result_i,
    output logic [3:0]        dbg_state_o
);

    localparam int BYTES = DATA_W / 8;
    localparam int BCW   = (BYTES > 1) ? $clog2(BYTES) : 1;

    localparam logic [15:0]          BYTES16   = 16'(BYTES);
    localparam logic [15:0]          TWO_OPS16 = 16'(2 * BYTES);
    localparam logic [BCW-1:0]       LAST_BYTE = BCW'(BYTES - 1);
    localparam logic [SER_CNT_W-1:0] RES_CNT   = SER_CNT_W'(BYTES);

    // Where a malformed packet ends up once its payload is gone.
`ifdef ALU_PACKET_ERR_RESP_EN
    localparam alu_pkt_state_e BAD_END = ERR;
`else
    localparam alu_pkt_state_e BAD_END = HDR_OP;
`endif

    alu_pkt_state_e    state_q, state_d;
    logic [7:0]        opcode_q, opcode_d;
    logic [7:0]        len_lo_q, len_lo_d;
    logic [15:0]       pay_cnt_q, pay_cnt_d;
    logic [BCW-1:0]    byte_cnt_q, byte_cnt_d;
    logic              first_q, first_d;
    logic              req_acked_q, req_acked_d;
    logic [DATA_W-1:0] acc_q, acc_d;
    logic [DATA_W-1:0] op_q, op_d;

    logic [15:0]          len_full;
    logic [15:0]          pay_len;
    logic                 add_mul_len_ok;
    logic                 div_len_ok;
    logic [DATA_W-1:0]    op_shift;
    logic                 op_last_byte;

    logic                 ser_load;
    logic [DATA_W-1:0]    ser_word;
    logic [SER_CNT_W-1:0] ser_cnt;
    logic                 ser_done;

    // Length as it stands while the MSB byte is on rx_data_i.
    assign len_full = {rx_data_i, len_lo_q};
    assign pay_len  = len_full - 16'(HDR_BYTES);

    assign add_mul_len_ok = (pay_len != 16'd0) && ((pay_len % BYTES16) == 16'd0)
                            && (pay_len >= TWO_OPS16);
    assign div_len_ok     = (pay_len == TWO_OPS16);

    // Little-endian assembly: new byte enters at the top, so after BYTES
    // bytes the first one received sits in bits [7:0].
    assign op_shift     = (DATA_W'(rx_data_i) << (DATA_W - 8)) | (op_q >> 8);
    assign op_last_byte = (byte_cnt_q == LAST_BYTE);

    assign op_sel_o    = (opcode_q == OPCODE_DIV);
    assign op_a_o      = acc_q;
    assign op_b_o      = op_q;
    assign dbg_state_o = state_q;

    always_comb begin
        state_d        = state_q;
        opcode_d       = opcode_q;
        len_lo_d       = len_lo_q;
        pay_cnt_d      = pay_cnt_q;
        byte_cnt_d     = byte_cnt_q;
        first_d        = first_q;
        req_acked_d    = req_acked_q;
        acc_d          = acc_q;
        op_d           = op_q;
        rx_ready_o     = 1'b0;
        op_req_valid_o = 1'b0;
        ser_load       = 1'b0;
        ser_word       = '0;
        ser_cnt        = '0;

        case (state_q)
            HDR_OP: begin
                rx_ready_o = 1'b1;
                if (rx_valid_i) begin
                    opcode_d    = rx_data_i;
                    byte_cnt_d  = '0;
                    first_d     = 1'b1;
                    req_acked_d = 1'b0;
                    state_d     = HDR_RSV;
                end
            end

            HDR_RSV: begin
                rx_ready_o = 1'b1;
                if (rx_valid_i) begin
                    state_d = LEN_LO;
                end
            end

            LEN_LO: begin
                rx_ready_o = 1'b1;
                if (rx_valid_i) begin
                    len_lo_d = rx_data_i;
                    state_d  = LEN_HI;
                end
            end

            LEN_HI: begin
                rx_ready_o = 1'b1;
                if (rx_valid_i) begin
                    pay_cnt_d = pay_len;
                    if (len_full < 16'(HDR_BYTES)) begin
                        pay_cnt_d = 16'd0;
                        state_d   = BAD_END;
                    end else if (opcode_q == OPCODE_ECHO) begin
                        state_d = (pay_len == 16'd0) ? HDR_OP : ECHO;
                    end else if (((opcode_q == OPCODE_ADD) || (opcode_q == OPCODE_MUL))
                                 && add_mul_len_ok) begin
                        state_d = COLLECT;
                    end else if ((opcode_q == OPCODE_DIV) && div_len_ok) begin
                        state_d = COLLECT;
                    end else begin
                        state_d = (pay_len == 16'd0) ? BAD_END : DRAIN;
                    end
                end
            end

            ECHO: begin
                // The serializer doubles as the single-entry tx register.
                rx_ready_o = !tx_valid_o && (pay_cnt_q != 16'd0);
                if (rx_valid_i && rx_ready_o) begin
                    pay_cnt_d = pay_cnt_q - 16'd1;
                    ser_load  = 1'b1;
                    ser_word  = DATA_W'(rx_data_i);
                    ser_cnt   = SER_CNT_W'(1);
                end
                if (ser_done && (pay_cnt_q == 16'd0)) begin
                    state_d = HDR_OP;
                end
            end

            COLLECT: begin
                rx_ready_o = 1'b1;
                if (rx_valid_i) begin
                    pay_cnt_d  = pay_cnt_q - 16'd1;
                    op_d       = op_shift;
                    byte_cnt_d = op_last_byte ? '0 : byte_cnt_q + BCW'(1);
                    if (op_last_byte) begin
                        if (first_q) begin
                            acc_d   = op_shift;
                            first_d = 1'b0;
                        end else if (opcode_q == OPCODE_ADD) begin
                            acc_d = acc_q + op_shift;
                            if (pay_cnt_q == 16'd1) begin
                                state_d = RESULT;
                            end
                        end else begin
                            state_d = EXEC;
                        end
                    end
                end
            end

            EXEC: begin
                op_req_valid_o = !req_acked_q;
                if (op_req_valid_o && op_req_ready_i) begin
                    req_acked_d = 1'b1;
                end
                // A strobe in the handshake cycle itself counts as the answer.
                if (op_resp_valid_i && (req_acked_q || op_req_ready_i)) begin
                    acc_d       = op_result_i;
                    req_acked_d = 1'b0;
                    state_d     = (pay_cnt_q == 16'd0) ? RESULT : COLLECT;
                end
            end

            RESULT: begin
                if (ser_done) begin
                    state_d = HDR_OP;
                end
            end

            DRAIN: begin
                rx_ready_o = 1'b1;
                if (rx_valid_i) begin
                    pay_cnt_d = pay_cnt_q - 16'd1;
                    if (pay_cnt_q == 16'd1) begin
                        state_d = BAD_END;
                    end
                end
            end

`ifdef ALU_PACKET_ERR_RESP_EN
            ERR: begin
                if (ser_done) begin
                    state_d = HDR_OP;
                end
            end
`endif

            default: begin
                state_d = HDR_OP;
            end
        endcase

        // Load the serializer on entry so the first byte is valid next cycle.
        if ((state_d == RESULT) && (state_q != RESULT)) begin
            ser_load = 1'b1;
            ser_word = acc_d;
            ser_cnt  = RES_CNT;
        end
`ifdef ALU_PACKET_ERR_RESP_EN
        if ((state_d == ERR) && (state_q != ERR)) begin
            ser_load = 1'b1;
            ser_word = DATA_W'(ERR_BYTE);
            ser_cnt  = SER_CNT_W'(1);
        end
`endif
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= HDR_OP;
            opcode_q    <= '0;
            len_lo_q    <= '0;
            pay_cnt_q   <= '0;
            byte_cnt_q  <= '0;
            first_q     <= 1'b1;
            req_acked_q <= 1'b0;
            acc_q       <= '0;
            op_q        <= '0;
        end else begin
            state_q     <= state_d;
            opcode_q    <= opcode_d;
            len_lo_q    <= len_lo_d;
            pay_cnt_q   <= pay_cnt_d;
            byte_cnt_q  <= byte_cnt_d;
            first_q     <= first_d;
            req_acked_q <= req_acked_d;
            acc_q       <= acc_d;
            op_q        <= op_d;
        end
    end

    alu_result_serializer #(
        .DATA_W (DATA_W)
    ) u_ser (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .load_i      (ser_load),
        .load_word_i (ser_word),
        .load_cnt_i  (ser_cnt),
        .tx_data_o   (tx_data_o),
        .tx_valid_o  (tx_valid_o),
        .tx_ready_i  (tx_ready_i),
        .done_o      (ser_done)
    );

endmodule

// File: tb/tb_alu_packet_engine.sv
// ----------------------------------------------------------------------------
// tb_alu_packet_engine
// Directed bench for alu_packet_engine: a 32-bit instance driven from a
// vector table plus hand sequences (MUL/DIV stub timing, tx backpressure,
// reset in RESULT), and a 16-bit instance for the narrow-width ADD case.
// ----------------------------------------------------------------------------
module tb_alu_packet_engine;
    import config_pkg::*;

`ifdef ALU_PACKET_ERR_RESP_EN
    localparam int ERR_N = 1;
`else
    localparam int ERR_N = 0;
`endif

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- 32-bit DUT ----------------
    logic [7:0]  rx_data, tx_data;
    logic        rx_valid, rx_ready, tx_valid, tx_ready;
    logic        op_req_valid, op_req_ready, op_sel, op_resp_valid;
    logic [31:0] op_a, op_b, op_result;
    logic [3:0]  dbg_state;

    alu_packet_engine #(.DATA_W(32)) u_dut (
        .clk_i(clk), .rst_i(rst),
        .rx_data_i(rx_data), .rx_valid_i(rx_valid), .rx_ready_o(rx_ready),
        .tx_data_o(tx_data), .tx_valid_o(tx_valid), .tx_ready_i(tx_ready),
        .op_req_valid_o(op_req_valid), .op_req_ready_i(op_req_ready),
        .op_sel_o(op_sel), .op_a_o(op_a), .op_b_o(op_b),
        .op_resp_valid_i(op_resp_valid), .op_result_i(op_result),
        .dbg_state_o(dbg_state)
    );

    // ---------------- 16-bit DUT ----------------
    logic [7:0]  rx_data16, tx_data16;
    logic        rx_valid16, rx_ready16, tx_valid16, tx_ready16;
    logic        op_req_valid16, op_req_ready16, op_sel16, op_resp_valid16;
    logic [15:0] op_a16, op_b16, op_result16;
    logic [3:0]  dbg_state16;

    alu_packet_engine #(.DATA_W(16)) u_dut16 (
        .clk_i(clk), .rst_i(rst),
        .rx_data_i(rx_data16), .rx_valid_i(rx_valid16), .rx_ready_o(rx_ready16),
        .tx_data_o(tx_data16), .tx_valid_o(tx_valid16), .tx_ready_i(tx_ready16),
        .op_req_valid_o(op_req_valid16), .op_req_ready_i(op_req_ready16),
        .op_sel_o(op_sel16), .op_a_o(op_a16), .op_b_o(op_b16),
        .op_resp_valid_i(op_resp_valid16), .op_result_i(op_result16),
        .dbg_state_o(dbg_state16)
    );

    // ---------------- scoreboard bookkeeping ----------------
    int chk_cnt  = 0;
    int pass_cnt = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        chk_cnt++;
        if (got === exp) pass_cnt++;
        else $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    endtask

    task automatic note_timeout(input string name);
        chk_cnt++;
        $display("FAIL %s: timed out waiting for the DUT", name);
    endtask

    // ---------------- monitors (sample on falling edge) ----------------
    logic [7:0] got_q[$];
    logic [7:0] got16_q[$];
    int   echo_acc_cnt = 0, echo_lat_err = 0, exec_cycles = 0, exec_err = 0;
    logic prev_echo_acc = 1'b0;

    always @(negedge clk) begin
        if (tx_valid && tx_ready) got_q.push_back(tx_data);
        if (tx_valid16 && tx_ready16) got16_q.push_back(tx_data16);
        // An echoed byte must be on tx the cycle after it was accepted.
        if (prev_echo_acc && !tx_valid) echo_lat_err++;
        prev_echo_acc = rx_valid && rx_ready && (dbg_state == ECHO);
        if (prev_echo_acc) echo_acc_cnt++;
        if (dbg_state == EXEC) begin
            exec_cycles++;
            if (rx_ready) exec_err++;
        end
    end

    // ---------------- MUL/DIV stub ----------------
    int          stub_rdy_delay = 2;
    int          stub_lat = 3;
    logic [31:0] last_a = '0, last_b = '0;

    initial begin
        int  rdy_wait;
        int  cd;
        bit  pend;
        logic signed [31:0] sa, sb;
        rdy_wait = 0; cd = 0; pend = 0;
        op_req_ready = 1'b0; op_resp_valid = 1'b0; op_result = '0;
        forever begin
            @(posedge clk); #1;
            op_req_ready  = 1'b0;
            op_resp_valid = 1'b0;
            if (pend) begin
                cd--;
                if (cd <= 0) begin
                    op_resp_valid = 1'b1;
                    pend = 0;
                end
            end else if (op_req_valid) begin
                if (rdy_wait < stub_rdy_delay) begin
                    rdy_wait++;
                end else begin
                    rdy_wait = 0;
                    op_req_ready = 1'b1;
                    last_a = op_a;
                    last_b = op_b;
                    sa = op_a;
                    sb = op_b;
                    if (op_sel) op_result = (sb == 0) ? 32'd0 : 32'(sa / sb);
                    else        op_result = 32'(sa * sb);
                    if (stub_lat == 0) op_resp_valid = 1'b1;
                    else begin pend = 1; cd = stub_lat; end
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic send_byte(input logic [7:0] b);
        logic rdy;
        rx_data  = b;
        rx_valid = 1'b1;
        for (int k = 0; k < 200; k++) begin
            rdy = rx_ready;
            @(posedge clk); #1;
            if (rdy) begin
                rx_valid = 1'b0;
                return;
            end
        end
        rx_valid = 1'b0;
        note_timeout("rx_accept");
    endtask

    task automatic send_byte16(input logic [7:0] b);
        logic rdy;
        rx_data16  = b;
        rx_valid16 = 1'b1;
        for (int k = 0; k < 200; k++) begin
            rdy = rx_ready16;
            @(posedge clk); #1;
            if (rdy) begin
                rx_valid16 = 1'b0;
                return;
            end
        end
        rx_valid16 = 1'b0;
        note_timeout("rx16_accept");
    endtask

    task automatic wait_idle(input string name);
        for (int k = 0; k < 300; k++) begin
            if ((dbg_state == HDR_OP) && !tx_valid) return;
            @(posedge clk); #1;
        end
        note_timeout(name);
    endtask

    typedef struct {
        string        name;
        logic [7:0]   opc;
        logic [15:0]  len;
        int           n_pl;
        logic [127:0] pl;   // byte j at pl[j*8 +: 8], sent in order j = 0..
        int           n_ex;
        logic [63:0]  ex;   // expected tx byte j at ex[j*8 +: 8]
    } vec_t;

    function automatic vec_t mk(input string nm, input logic [7:0] opc, input logic [15:0] len,
                                input int npl, input logic [127:0] pl, input int nex,
                                input logic [63:0] ex);
        vec_t v;
        v.name = nm; v.opc = opc; v.len = len; v.n_pl = npl; v.pl = pl;
        v.n_ex = nex; v.ex = ex;
        return v;
    endfunction

    task automatic send_pkt(input vec_t v);
        send_byte(v.opc);
        send_byte(8'h00);
        send_byte(v.len[7:0]);
        send_byte(v.len[15:8]);
        for (int j = 0; j < v.n_pl; j++) send_byte(v.pl[j*8 +: 8]);
    endtask

    task automatic run_vec(input vec_t v);
        int base;
        logic [7:0] g;
        base = got_q.size();
        send_pkt(v);
        wait_idle({v.name, "_idle"});
        check({v.name, "_count"}, 64'(got_q.size() - base), 64'(v.n_ex));
        for (int j = 0; j < v.n_ex; j++) begin
            g = (base + j < got_q.size()) ? got_q[base + j] : 8'hxx;
            check($sformatf("%s_byte%0d", v.name, j), 64'(g), 64'(v.ex[j*8 +: 8]));
        end
        check({v.name, "_state"}, 64'(dbg_state), 64'(HDR_OP));
    endtask

    vec_t vecs[12];

    // ---------------- main sequence ----------------
    initial begin
        int base;
        rst = 1'b1;
        rx_data = '0; rx_valid = 1'b0; tx_ready = 1'b1;
        rx_data16 = '0; rx_valid16 = 1'b0; tx_ready16 = 1'b1;
        op_req_ready16 = 1'b0; op_resp_valid16 = 1'b0; op_result16 = '0;
        repeat (3) @(posedge clk);
        #1;

        // Reset state
        check("rst_rx_ready", 64'(rx_ready), 64'd1);
        check("rst_tx_valid", 64'(tx_valid), 64'd0);
        check("rst_tx_data", 64'(tx_data), 64'd0);
        check("rst_req_valid", 64'(op_req_valid), 64'd0);
        check("rst_op_a", 64'(op_a), 64'd0);
        check("rst_op_b", 64'(op_b), 64'd0);
        check("rst_op_sel", 64'(op_sel), 64'd0);
        check("rst_state", 64'(dbg_state), 64'(HDR_OP));
        check("rst16_rx_ready", 64'(rx_ready16), 64'd1);
        rst = 1'b0;
        @(posedge clk); #1;

        vecs[0]  = mk("echo_hello", OPCODE_ECHO, 16'd9, 5, 128'h6f_6c_6c_65_68, 5, 64'h6f_6c_6c_65_68);
        vecs[1]  = mk("add3", OPCODE_ADD, 16'd16, 12, 128'({32'h5, 32'h2, 32'hFFFF_FFFF}), 4, 64'h0000_0006);
        vecs[2]  = mk("div_badlen", OPCODE_DIV, 16'd16, 12, 128'({32'h9, 32'h8, 32'h7}), ERR_N, 64'(ERR_BYTE));
        vecs[3]  = mk("echo_empty", OPCODE_ECHO, 16'd4, 0, 128'h0, 0, 64'h0);
        vecs[4]  = mk("len_short", OPCODE_ADD, 16'd2, 0, 128'h0, ERR_N, 64'(ERR_BYTE));
        vecs[5]  = mk("unknown_op", 8'h55, 16'd6, 2, 128'hCD_AB, ERR_N, 64'(ERR_BYTE));
        vecs[6]  = mk("add_one_op", OPCODE_ADD, 16'd8, 4, 128'h0000_0001, ERR_N, 64'(ERR_BYTE));
        vecs[7]  = mk("add_ragged", OPCODE_ADD, 16'd14, 10, 128'h0102_0000_0003_0000_0004, ERR_N, 64'(ERR_BYTE));
        vecs[8]  = mk("mul3", OPCODE_MUL, 16'd16, 12, 128'({32'd4, 32'd3, 32'd2}), 4, 64'h0000_0018);
        vecs[9]  = mk("div_ok", OPCODE_DIV, 16'd12, 8, 128'({32'hFFFF_FFF9, 32'd100}), 4, 64'hFFFF_FFF2);
        vecs[10] = mk("add_wrap", OPCODE_ADD, 16'd12, 8, 128'({32'h1, 32'hFFFF_FFFF}), 4, 64'h0);
        vecs[11] = mk("echo_one", OPCODE_ECHO, 16'd5, 1, 128'h5A, 1, 64'h5A);

        for (int i = 0; i < 12; i++) run_vec(vecs[i]);

        // MUL -3 * 7 with ready held low 2 cycles and a 3-cycle response.
        stub_rdy_delay = 2; stub_lat = 3;
        run_vec(mk("mul_neg", OPCODE_MUL, 16'd12, 8, 128'({32'd7, 32'hFFFF_FFFD}), 4, 64'hFFFF_FFEB));
        check("mul_req_a", 64'(last_a), 64'hFFFF_FFFD);
        check("mul_req_b", 64'(last_b), 64'd7);
        check("exec_seen", 64'(exec_cycles > 0), 64'd1);
        check("exec_rx_ready_low", 64'(exec_err), 64'd0);

        // Response in the same cycle as the request handshake.
        stub_rdy_delay = 0; stub_lat = 0;
        run_vec(mk("mul_samecyc", OPCODE_MUL, 16'd12, 8, 128'({32'd6, 32'd5}), 4, 64'h0000_001E));

        check("echo_latency", 64'(echo_lat_err), 64'd0);
        check("echo_accepts", 64'(echo_acc_cnt), 64'd6);

        // Backpressure in RESULT, then reset after 2 of 4 bytes.
        tx_ready = 1'b0;
        base = got_q.size();
        send_pkt(mk("add_rst", OPCODE_ADD, 16'd12, 8, 128'({32'h1111_1111, 32'h1234_5678}), 0, 64'h0));
        begin
            bit seen;
            seen = 0;
            for (int k = 0; k < 20; k++) begin
                if (tx_valid) begin seen = 1; break; end
                @(posedge clk); #1;
            end
            if (!seen) note_timeout("result_valid");
        end
        check("hold_data0", 64'(tx_data), 64'h89);
        repeat (4) @(posedge clk);
        #1;
        check("hold_valid", 64'(tx_valid), 64'd1);
        check("hold_data1", 64'(tx_data), 64'h89);
        check("result_rx_ready", 64'(rx_ready), 64'd0);
        tx_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_pre_count", 64'(got_q.size() - base), 64'd2);
        check("rst_pre_b0", 64'(got_q[base]), 64'h89);
        check("rst_pre_b1", 64'(got_q[base + 1]), 64'h67);
        rst = 1'b1;
        #1;
        check("rst_mid_tx_valid", 64'(tx_valid), 64'd0);
        check("rst_mid_tx_data", 64'(tx_data), 64'd0);
        check("rst_mid_rx_ready", 64'(rx_ready), 64'd1);
        check("rst_mid_state", 64'(dbg_state), 64'(HDR_OP));
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        check("rst_no_more_tx", 64'(got_q.size() - base), 64'd2);
        run_vec(mk("add_after_rst", OPCODE_ADD, 16'd12, 8, 128'({32'd2, 32'd1}), 4, 64'h0000_0003));

        // 16-bit instance: 0x8000 + 0x8001 wraps to 0x0001.
        send_byte16(OPCODE_ADD);
        send_byte16(8'h00);
        send_byte16(8'h08);
        send_byte16(8'h00);
        send_byte16(8'h00);
        send_byte16(8'h80);
        send_byte16(8'h01);
        send_byte16(8'h80);
        begin
            bit idle;
            idle = 0;
            for (int k = 0; k < 50; k++) begin
                if ((dbg_state16 == HDR_OP) && !tx_valid16) begin idle = 1; break; end
                @(posedge clk); #1;
            end
            if (!idle) note_timeout("w16_idle");
        end
        repeat (3) @(posedge clk);
        #1;
        check("w16_count", 64'(got16_q.size()), 64'd2);
        check("w16_b0", 64'(got16_q.size() > 0 ? got16_q[0] : 8'hxx), 64'h01);
        check("w16_b1", 64'(got16_q.size() > 1 ? got16_q[1] : 8'hxx), 64'h00);
        check("w16_no_req", 64'(op_req_valid16), 64'd0);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
